out_merge_network: RTL and testbench

OUT_MERGE_NETWORK -- requirements
Module: out_merge_network

---
 rtl/out_merge_network.sv | 175 +++++++++++++++++
 tb/tb_out_merge_network.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/out_merge_network.sv
// Merges ncount processing-node streams into one packet-atomic output stream.
// Round-robin arbitration happens only between packets; once a packet starts,
// its node holds the grant until the eop word is accepted. A 2-entry FIFO
// decouples the merged stream from downstream backpressure. Words arriving
// without sop outside a packet are orphans: they are consumed and counted.
module out_merge_network #(
  parameter int ncount = 8
) (
  input  logic                     clock,
  input  logic                     resetn,
  input  logic [ncount*142-1:0]    pnode_data,
  input  logic [ncount-1:0]        pnode_valid,
  output logic [ncount-1:0]        pnode_ready,
  output logic [127:0]             st_data,
  output logic [11:0]              st_channel,
  output logic                     st_sop,
  output logic                     st_eop,
  output logic                     st_valid,
  input  logic                     st_ready,
  output logic [15:0]              drop_count
);

  localparam int WORD_W = 142;
  localparam int PTR_W  = $clog2(ncount);
  localparam int SOP_B  = 129;
  localparam int EOP_B  = 128;

  typedef enum logic {
    IDLE = 1'b0,
    PKT  = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]   grant_q, grant_d;
  logic [1:0]         count_q, count_d;
  logic [15:0]        drop_q, drop_d;

  logic [WORD_W-1:0]  node_word [ncount];
  logic               found;
  logic [PTR_W-1:0]   sel_idx;
  int                 idx;

  logic [PTR_W-1:0]   act_idx;
  logic [WORD_W-1:0]  act_word_p0;
  logic               can_accept;
  logic               push;
  logic               pop;
  logic               vld_p1;
  logic [ncount-1:0]  ready_vec;

  logic [WORD_W-1:0]  head_p1;
  logic [WORD_W-1:0]  tail_p1;

  for (genvar g = 0; g < ncount; g++) begin : g_unpack
    assign node_word[g] = pnode_data[g*WORD_W +: WORD_W];
  end

  // Round-robin search: first valid node after rr_ptr, wrapping modulo ncount.
  always_comb begin
    idx     = 0;
    found   = 1'b0;
    sel_idx = '0;
    for (int k = 1; k <= ncount; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= ncount) idx = idx - ncount;
      if (!found && pnode_valid[idx[PTR_W-1:0]]) begin
        found   = 1'b1;
        sel_idx = idx[PTR_W-1:0];
      end
    end
  end

  // ---- stage p0: word selection and acceptance decision ----
  assign act_idx     = (state_q == PKT) ? grant_q : sel_idx;
  assign act_word_p0 = node_word[act_idx];

  // Room is judged on the registered count only, so a same-cycle pop never
  // creates space; this keeps the ready path free of st_ready.
  assign can_accept = (count_q < 2'd2);
  assign vld_p1     = (count_q != 2'd0);
  assign pop        = vld_p1 & st_ready;

  // Next-state, ready and push decisions for the IDLE/PKT arbiter.
  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    grant_d   = grant_q;
    drop_d    = drop_q;
    ready_vec = '0;
    push      = 1'b0;
    case (state_q)
      IDLE: begin
        if (found) begin
          if (act_word_p0[SOP_B]) begin
            ready_vec[sel_idx] = can_accept;
            if (can_accept) begin
              push = 1'b1;
              if (act_word_p0[EOP_B]) begin
                rr_ptr_d = sel_idx;
              end else begin
                state_d = PKT;
                grant_d = sel_idx;
              end
            end
          end else begin
            // Orphans never enter the FIFO, so they are drained even when full.
            ready_vec[sel_idx] = 1'b1;
            rr_ptr_d           = sel_idx;
            if (drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
          end
        end
      end
      PKT: begin
        ready_vec[grant_q] = can_accept;
        if (can_accept && pnode_valid[grant_q]) begin
          push = 1'b1;
          if (act_word_p0[EOP_B]) begin
            state_d  = IDLE;
            rr_ptr_d = grant_q;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FIFO occupancy follows push and pop of the current cycle.
  always_comb begin
    count_d = count_q + {1'b0, push} - {1'b0, pop};
  end

  // ---- stage p1: registered control state and FIFO occupancy ----
  // Control registers, cleared asynchronously so a reset abandons any packet.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      rr_ptr_q <= PTR_W'(ncount - 1);
      grant_q  <= '0;
      count_q  <= 2'd0;
      drop_q   <= 16'd0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      count_q  <= count_d;
      drop_q   <= drop_d;
    end
  end

  // FIFO storage; head is what st_* presents, tail is the second entry.
  always_ff @(posedge clock) begin
    if (push && ((count_q == 2'd0) || ((count_q == 2'd1) && pop))) begin
      head_p1 <= act_word_p0;
    end else if (push) begin
      tail_p1 <= act_word_p0;
    end else if (pop && (count_q == 2'd2)) begin
      head_p1 <= tail_p1;
    end
  end

  // Ready is forced low while reset is held, independent of the arbiter.
  assign pnode_ready = resetn ? ready_vec : '0;

  // Empty FIFO (including during reset) shows an all-zero word.
  assign st_valid   = vld_p1;
  assign st_data    = vld_p1 ? head_p1[127:0]   : 128'd0;
  assign st_channel = vld_p1 ? head_p1[141:130] : 12'd0;
  assign st_sop     = vld_p1 ? head_p1[SOP_B]   : 1'b0;
  assign st_eop     = vld_p1 ? head_p1[EOP_B]   : 1'b0;
  assign drop_count = drop_q;

endmodule

// File: tb/tb_out_merge_network.sv
// Bench for out_merge_network: per-node source queues feed the DUT, a
// transaction-level model (queue of words owed downstream, packet owner,
// last-served node) predicts ready, output words and drop count each cycle.
module tb_out_merge_network;

  localparam int N = 8;
  localparam int W = 142;

  logic             clock = 1'b0;
  logic             resetn = 1'b0;
  logic [N*W-1:0]   pnode_data;
  logic [N-1:0]     pnode_valid;
  logic [N-1:0]     pnode_ready;
  logic [127:0]     st_data;
  logic [11:0]      st_channel;
  logic             st_sop;
  logic             st_eop;
  logic             st_valid;
  logic             st_ready;
  logic [15:0]      drop_count;

  out_merge_network #(.ncount(N)) dut (
    .clock      (clock),
    .resetn     (resetn),
    .pnode_data (pnode_data),
    .pnode_valid(pnode_valid),
    .pnode_ready(pnode_ready),
    .st_data    (st_data),
    .st_channel (st_channel),
    .st_sop     (st_sop),
    .st_eop     (st_eop),
    .st_valid   (st_valid),
    .st_ready   (st_ready),
    .drop_count (drop_count)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int passes = 0;

  logic [W-1:0] src [N][$];
  logic [N-1:0] fire_q = '0;
  logic [W-1:0] mq[$];
  bit           minpkt = 1'b0;
  int           mown = 0;
  int           mlast = N - 1;
  int           mdrop = 0;
  logic [W-1:0] out_log[$];
  int           grant_log[$];
  bit           rand_ready = 1'b0;
  bit           rand_gaps = 1'b0;
  bit           st_hold = 1'b1;

  task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s got=%h exp=%h", name, got, exp);
  endtask

  function automatic logic [W-1:0] mkw(input logic [11:0] ch, input logic sop,
                                       input logic eop, input logic [127:0] d);
    return {ch, sop, eop, d};
  endfunction

  function automatic logic [W-1:0] nword(input int i);
    return pnode_data[i*W +: W];
  endfunction

  function automatic bit srcs_empty();
    for (int i = 0; i < N; i++) if (src[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  // Reference model and per-cycle compare, sampled on the falling edge.
  initial begin
    logic [N-1:0] er;
    logic [W-1:0] w, acc_w, dutw;
    int sel, ix;
    bit pop, push;
    forever begin
      @(negedge clock);
      dutw = {st_channel, st_sop, st_eop, st_data};
      if (!resetn) begin
        chk("rst_ready", W'(pnode_ready), '0);
        chk("rst_valid", W'(st_valid), '0);
        chk("rst_word", dutw, '0);
        chk("rst_drop", W'(drop_count), '0);
        mq.delete();
        minpkt = 1'b0; mown = 0; mlast = N - 1; mdrop = 0;
        fire_q = '0;
      end else begin
        fire_q = pnode_valid & pnode_ready;
        for (int i = 0; i < N; i++) if (fire_q[i]) grant_log.push_back(i);
        if (st_valid && st_ready) out_log.push_back(dutw);
        er = '0; sel = -1;
        if (minpkt) begin
          er[mown] = (mq.size() < 2);
        end else begin
          for (int k = 1; k <= N; k++) begin
            ix = (mlast + k) % N;
            if (sel < 0 && pnode_valid[ix]) sel = ix;
          end
          if (sel >= 0) begin
            w = nword(sel);
            er[sel] = w[129] ? (mq.size() < 2) : 1'b1;
          end
        end
        chk("ready", W'(pnode_ready), W'(er));
        chk("st_valid", W'(st_valid), W'(mq.size() != 0));
        if (mq.size() != 0) chk("st_word", dutw, mq[0]);
        chk("drop", W'(drop_count), W'(mdrop));
        pop = (mq.size() != 0) && st_ready;
        push = 1'b0; acc_w = '0;
        for (int i = 0; i < N; i++) begin
          if (er[i] && pnode_valid[i]) begin
            w = nword(i);
            if (minpkt) begin
              push = 1'b1; acc_w = w;
              if (w[128]) begin minpkt = 1'b0; mlast = mown; end
            end else if (w[129]) begin
              push = 1'b1; acc_w = w;
              if (w[128]) mlast = i;
              else begin minpkt = 1'b1; mown = i; end
            end else begin
              if (mdrop < 65535) mdrop++;
              mlast = i;
            end
          end
        end
        if (pop) void'(mq.pop_front());
        if (push) mq.push_back(acc_w);
      end
    end
  end

  // Source driver: valid is held until the word is taken.
  initial begin
    pnode_valid = '0;
    pnode_data  = '0;
    st_ready    = 1'b1;
    forever begin
      @(posedge clock);
      #1;
      for (int i = 0; i < N; i++)
        if (fire_q[i] && src[i].size() != 0) void'(src[i].pop_front());
      for (int i = 0; i < N; i++) begin
        if (src[i].size() == 0) begin
          pnode_valid[i] = 1'b0;
          pnode_data[i*W +: W] = '0;
        end else begin
          if (!pnode_valid[i] || fire_q[i])
            pnode_valid[i] = rand_gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
          pnode_data[i*W +: W] = src[i][0];
        end
      end
      st_ready = rand_ready ? ($urandom_range(0, 3) != 0) : st_hold;
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic do_reset();
    tick();
    resetn = 1'b0;
    for (int i = 0; i < N; i++) src[i].delete();
    tick();
    tick();
    resetn = 1'b1;
  endtask

  task automatic drain(input int budget, input string name);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clock);
      if (srcs_empty() && !st_valid && pnode_valid == '0) begin
        ok = 1'b1;
        break;
      end
    end
    chk(name, W'(ok), W'(1));
  endtask

  task automatic push_pkt(input int node, input int len, input logic [11:0] ch,
                          input logic [127:0] base, input bit rand_sop);
    logic s;
    for (int k = 0; k < len; k++) begin
      s = (k == 0) ? 1'b1 : (rand_sop ? ($urandom_range(0, 7) == 0) : 1'b0);
      src[node].push_back(mkw(ch, s, (k == len - 1), base + 128'(k)));
    end
  endtask

  initial begin
    logic [127:0] xdata;
    bit seen;
    int lat;
    int node;

    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("lit_reset_valid", W'(st_valid), '0);
    tick();
    resetn = 1'b1;

    // Single-word packet on node 3.
    xdata = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_5555_AAAA;
    tick();
    src[3].push_back(mkw(12'h005, 1'b1, 1'b1, xdata));
    seen = 1'b0; lat = -1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      if (st_valid) begin seen = 1'b1; lat = c; break; end
    end
    chk("lit_single_seen", W'(seen), W'(1));
    chk("lit_single_latency", W'(lat), W'(2));
    chk("lit_single_chan", W'(st_channel), W'(12'h005));
    chk("lit_single_data", W'(st_data), W'(xdata));
    chk("lit_single_drop", W'(drop_count), '0);
    drain(50, "drain_single");

    // Two simultaneous 4-word packets: node 0 then node 1, contiguous.
    tick();
    out_log.delete();
    push_pkt(0, 4, 12'h000, 128'h000, 1'b0);
    push_pkt(1, 4, 12'h001, 128'h100, 1'b0);
    drain(100, "drain_two_pkts");
    chk("lit_two_size", W'(out_log.size()), W'(8));
    for (int i = 0; i < 8 && i < out_log.size(); i++)
      chk("lit_two_order", W'(out_log[i][127:0]),
          W'((i < 4) ? (128'h000 + 128'(i)) : (128'h100 + 128'(i - 4))));

    // All nodes streaming single-word packets: strict rotation.
    do_reset();
    grant_log.delete();
    for (int i = 0; i < N; i++) begin
      src[i].push_back(mkw(12'(i), 1'b1, 1'b1, 128'(i)));
      src[i].push_back(mkw(12'(i), 1'b1, 1'b1, 128'(i + 16)));
    end
    drain(100, "drain_rotation");
    chk("lit_rot_size", W'(grant_log.size()), W'(16));
    for (int i = 0; i < 16 && i < grant_log.size(); i++)
      chk("lit_rot_order", W'(grant_log[i]), W'(i % 8));

    // Backpressure mid-packet.
    tick();
    out_log.delete();
    st_hold = 1'b0;
    push_pkt(5, 6, 12'h055, 128'h500, 1'b0);
    repeat (5) tick();
    @(negedge clock);
    chk("lit_bp_full", W'(st_valid), W'(1));
    chk("lit_bp_ready", W'(pnode_ready), '0);
    tick();
    st_hold = 1'b1;
    drain(100, "drain_bp");
    chk("lit_bp_size", W'(out_log.size()), W'(6));
    for (int i = 0; i < 6 && i < out_log.size(); i++)
      chk("lit_bp_order", W'(out_log[i][127:0]), W'(128'h500 + 128'(i)));

    // Orphan words on node 2.
    do_reset();
    out_log.delete();
    for (int i = 0; i < 3; i++) src[2].push_back(mkw(12'h002, 1'b0, 1'b0, 128'(i)));
    drain(100, "drain_orphans");
    chk("lit_orphan_drop", W'(drop_count), W'(3));
    chk("lit_orphan_out", W'(out_log.size()), '0);

    // Reset in the middle of a 6-word packet.
    tick();
    out_log.delete();
    push_pkt(3, 6, 12'h033, 128'h300, 1'b0);
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clock);
      if (out_log.size() >= 2) begin seen = 1'b1; break; end
    end
    chk("lit_midrst_progress", W'(seen), W'(1));
    tick();
    resetn = 1'b0;
    #1;
    chk("lit_midrst_valid", W'(st_valid), '0);
    chk("lit_midrst_ready", W'(pnode_ready), '0);
    src[3].delete();
    tick();
    tick();
    resetn = 1'b1;
    out_log.delete();
    push_pkt(3, 2, 12'h033, 128'h3A0, 1'b0);
    src[0].push_back(mkw(12'h000, 1'b1, 1'b1, 128'hF0));
    drain(100, "drain_midrst");
    chk("lit_midrst_size", W'(out_log.size()), W'(3));
    if (out_log.size() > 0)
      chk("lit_midrst_first", out_log[0], mkw(12'h000, 1'b1, 1'b1, 128'hF0));

    // Randomized traffic with gaps, backpressure, orphans and mid-packet sop.
    rand_ready = 1'b1;
    rand_gaps  = 1'b1;
    for (int t = 0; t < 400; t++) begin
      tick();
      if ($urandom_range(0, 1) == 1) begin
        node = int'($urandom_range(0, N - 1));
        if ($urandom_range(0, 7) == 0)
          src[node].push_back(mkw(12'($urandom), 1'b0, 1'($urandom_range(0, 1)),
                                  {$urandom, $urandom, $urandom, $urandom}));
        else
          push_pkt(node, int'($urandom_range(1, 5)), 12'($urandom),
                   {$urandom, $urandom, $urandom, $urandom}, 1'b1);
      end
    end
    drain(8000, "drain_random");
    rand_ready = 1'b0;
    rand_gaps  = 1'b0;
    tick();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
